// File: rtl/wbs_node_loader.sv
// Wishbone slave for the KD-tree internal-node window: forwards packed {median, index}
// writes to the node SRAM, serves read-back and tracks which nodes have been loaded.
module wbs_node_loader #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned NUM_NODES  = 63,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter logic [31:0] BASE_ADDR  = 32'h3004_0000,
   parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_we_i,
   input  logic [3:0]                wbs_sel_i,
   input  logic [31:0]               wbs_adr_i,
   input  logic [31:0]               wbs_dat_i,
   output logic                      wbs_ack_o,
   output logic [31:0]               wbs_dat_o,
   input  logic                      load_en,
   input  logic                      clear_i,
   output logic                      node_wen,
   output logic                      node_ren,
   output logic [ADDR_WIDTH-1:0]     node_addr,
   output logic [2*DATA_WIDTH-1:0]   node_wdata,
   input  logic [2*DATA_WIDTH-1:0]   node_rdata,
   output logic [ADDR_WIDTH-1:0]     loaded_cnt,
   output logic                      all_loaded,
   output logic                      addr_err
);

   localparam int unsigned WW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_ACK,
      S_RD_REQ,
      S_RD_ACK
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WW-1:0]         r_wdata;
   logic                  r_off_ok;
   logic                  r_sel_ok;
   logic [NUM_NODES-1:0]  r_loaded;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_err;

   logic                  w_hit;
   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_off_ok;
   logic                  w_commit;
   logic                  w_drop;
   logic [NUM_NODES-1:0]  w_onehot;
   logic                  w_unused;

   assign w_hit    = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign w_off    = wbs_adr_i[ADDR_WIDTH-1:0];
   assign w_off_ok = (wbs_adr_i[15:ADDR_WIDTH] == '0) && (w_off != '0)
                     && (32'(w_off) <= NUM_NODES);
   assign w_unused = ^{wbs_sel_i[3], wbs_dat_i[31:WW]};

   assign w_commit = (r_state == S_WR_ACK) && r_off_ok && r_sel_ok && load_en;
   assign w_drop   = ((r_state == S_WR_ACK) && !w_commit)
                   || ((r_state == S_RD_ACK) && !r_off_ok);
   assign w_onehot = NUM_NODES'(1) << r_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_off_ok <= 1'b0;
         r_sel_ok <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_hit) begin
            r_addr   <= w_off - ADDR_WIDTH'(1);
            r_off_ok <= w_off_ok;
            r_sel_ok <= &wbs_sel_i[2:0];
            if (wbs_we_i) begin
               r_wdata <= wbs_dat_i[WW-1:0];
            end
         end
      end
   end

   // A clear coinciding with a commit wipes the map first, then counts the new node.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_loaded <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else if (clear_i) begin
         r_loaded <= w_commit ? w_onehot : '0;
         r_cnt    <= w_commit ? ADDR_WIDTH'(1) : '0;
         r_err    <= w_drop;
      end else begin
         if (w_commit && !r_loaded[r_addr]) begin
            r_loaded <= r_loaded | w_onehot;
            r_cnt    <= r_cnt + ADDR_WIDTH'(1);
         end
         if (w_drop) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               if (wbs_we_i)      w_next = S_WR_ACK;
               else if (w_off_ok) w_next = S_RD_REQ;
               else               w_next = S_RD_ACK;
            end
         end
         S_WR_ACK: w_next = S_IDLE;
         S_RD_REQ: w_next = wbs_cyc_i ? S_RD_ACK : S_IDLE;
         S_RD_ACK: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Strobes are gated by reset so a reset landing in WR_ACK neither acks nor writes.
   always_comb begin
      wbs_ack_o = 1'b0;
      wbs_dat_o = '0;
      node_wen  = 1'b0;
      node_ren  = 1'b0;
      if (rst_n) begin
         unique case (r_state)
            S_WR_ACK: begin
               wbs_ack_o = 1'b1;
               node_wen  = w_commit;
            end
            S_RD_REQ: node_ren = 1'b1;
            S_RD_ACK: begin
               wbs_ack_o = 1'b1;
               if (r_off_ok) begin
                  wbs_dat_o = {{(32-WW){1'b0}}, node_rdata};
               end
            end
            default: ;
         endcase
      end
   end

   assign node_addr  = r_addr;
   assign node_wdata = r_wdata;
   assign loaded_cnt = r_cnt;
   assign all_loaded = (r_cnt == ADDR_WIDTH'(NUM_NODES));
   assign addr_err   = r_err;

endmodule

// File: tb/tb_wbs_node_loader.sv
// Directed bench for wbs_node_loader: scoreboard of expected acks plus a bench-side
// node SRAM and bitmap model.
module tb_wbs_node_loader;

   localparam logic [31:0] BASE = 32'h3004_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        load_en, clear_i;
   logic        node_wen, node_ren;
   logic [5:0]  node_addr;
   logic [21:0] node_wdata;
   logic [21:0] node_rdata;
   logic [5:0]  loaded_cnt;
   logic        all_loaded, addr_err;

   always #5 clk = ~clk;

   wbs_node_loader #(
      .DATA_WIDTH(11), .NUM_NODES(63), .ADDR_WIDTH(6),
      .BASE_ADDR(32'h3004_0000), .ADDR_MASK(32'hFFFF_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .load_en(load_en), .clear_i(clear_i),
      .node_wen(node_wen), .node_ren(node_ren), .node_addr(node_addr),
      .node_wdata(node_wdata), .node_rdata(node_rdata),
      .loaded_cnt(loaded_cnt), .all_loaded(all_loaded), .addr_err(addr_err)
   );

   // Downstream node SRAM: synchronous write, read data valid the cycle after ren.
   logic [21:0] sram [64];
   always @(posedge clk) begin
      if (node_wen) sram[node_addr] <= node_wdata;
      if (node_ren) node_rdata <= sram[node_addr];
   end

   typedef struct {
      logic [31:0] dat;
      logic        wen;
      logic [5:0]  addr;
      logic [21:0] wdata;
   } exp_t;
   exp_t exp_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   logic [21:0] ref_mem [64];
   bit          m_loaded [64];
   int          m_cnt;
   logic        m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   logic prev_ack = 1'b0;
   always @(negedge clk) begin
      if (wbs_ack_o === 1'b1) begin
         chk("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", {31'b0, wbs_ack_o}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_dat_o", wbs_dat_o, e.dat);
            chk("ack_node_wen", {31'b0, node_wen}, {31'b0, e.wen});
            if (e.wen) begin
               chk("ack_node_addr", {26'b0, node_addr}, {26'b0, e.addr});
               chk("ack_node_wdata", {10'b0, node_wdata}, {10'b0, e.wdata});
            end
         end
      end
      prev_ack <= wbs_ack_o;
   end

   function automatic logic [31:0] nd(input int off);
      logic [10:0] med, idx;
      med = 11'((off * 97 + 13) % 2048);
      idx = 11'((off * 29 + 1) % 2048);
      return {10'h2A5, med, idx};
   endfunction

   function automatic bit off_valid(input logic [31:0] a);
      return (a[15:6] == 10'd0) && (a[5:0] != 6'd0) && (a[5:0] <= 6'd63);
   endfunction

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit hold, input logic clr,
                       input int lat, input string tag);
      int  n;
      bit  got;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      n = 0; got = 1'b0;
      while (!got && n < 8) begin
         @(posedge clk); #1;
         n++;
         if (wbs_ack_o === 1'b1) got = 1'b1;
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      if (!hold) begin
         cyc = 1'b0; stb = 1'b0; we = 1'b0;
         clear_i = clr;
         @(posedge clk); #1;
         clear_i = 1'b0;
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit hold, input logic clr, input int lat, input string tag);
      exp_t e;
      bit   commit;
      int   idx;
      commit = off_valid(a) && load_en && (s[2:0] == 3'b111);
      idx    = int'(a[5:0]) - 1;
      e.dat = 32'd0; e.wen = commit; e.addr = 6'(idx); e.wdata = d[21:0];
      exp_q.push_back(e);
      if (clr) begin
         for (int i = 0; i < 64; i++) m_loaded[i] = 1'b0;
         m_cnt = 0; m_err = 1'b0;
      end
      if (commit) begin
         ref_mem[idx] = d[21:0];
         if (!m_loaded[idx]) begin
            m_loaded[idx] = 1'b1;
            m_cnt++;
         end
      end else begin
         m_err = 1'b1;
      end
      xfer(1'b1, a, d, s, hold, clr, lat, tag);
   endtask

   task automatic do_read(input logic [31:0] a, input string tag);
      exp_t e;
      e.dat = off_valid(a) ? {10'b0, ref_mem[int'(a[5:0]) - 1]} : 32'd0;
      e.wen = 1'b0; e.addr = '0; e.wdata = '0;
      exp_q.push_back(e);
      if (!off_valid(a)) m_err = 1'b1;
      xfer(1'b0, a, 32'd0, 4'hF, 1'b0, 1'b0, off_valid(a) ? 2 : 1, tag);
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_cnt"}, 32'(loaded_cnt), 32'(m_cnt));
      chk({tag, "_all"}, {31'b0, all_loaded}, {31'b0, m_cnt == 63});
      chk({tag, "_err"}, {31'b0, addr_err}, {31'b0, m_err});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 64; i++) begin
         sram[i] = '0; ref_mem[i] = '0; m_loaded[i] = 1'b0;
      end
      m_cnt = 0; m_err = 1'b0;
      rst_n = 1'b0; load_en = 1'b1; clear_i = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 1; dat_i = 32'h1234;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
      chk("rst_dat", wbs_dat_o, 32'd0);
      chk("rst_wen", {31'b0, node_wen}, 32'd0);
      chk("rst_ren", {31'b0, node_ren}, 32'd0);
      chk("rst_addr", {26'b0, node_addr}, 32'd0);
      chk("rst_wdata", {10'b0, node_wdata}, 32'd0);
      chk_status("rst");
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("idle_no_ack", {31'b0, wbs_ack_o}, 32'd0);

      do_write(BASE + 1, {10'd0, 11'd55, 11'd1}, 4'hF, 1'b0, 1'b0, 1, "wr1");
      chk_status("wr1");
      do_read(BASE + 1, "rd1");
      chk("rd1_value", {10'b0, ref_mem[0]}, 32'h0001_B801);

      for (int off = 1; off <= 63; off++) begin
         do_write(BASE + 32'(off), nd(off), 4'hF, off != 63, 1'b0, off == 1 ? 1 : 2, "burst");
      end
      chk_status("burst");
      do_read(BASE + 63, "rd63");
      do_read(BASE + 32, "rd32");
      do_write(BASE + 5, nd(500), 4'hF, 1'b0, 1'b0, 1, "rewrite5");
      chk_status("rewrite5");

      do_write(BASE + 0, nd(7), 4'hF, 1'b0, 1'b0, 1, "wr_off0");
      chk_status("wr_off0");
      do_write(BASE + 32'h40, nd(8), 4'hF, 1'b0, 1'b0, 1, "wr_0x40");
      do_write(BASE + 2, nd(9), 4'b1011, 1'b0, 1'b0, 1, "wr_sel");
      load_en = 1'b0;
      do_write(BASE + 2, nd(10), 4'hF, 1'b0, 1'b0, 1, "wr_noload");
      load_en = 1'b1;
      chk_status("dropped");
      do_read(BASE + 2, "rd2_unchanged");
      do_read(BASE + 0, "rd_off0");

      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3003_0001; dat_i = nd(11); sel = 4'hF;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (wbs_ack_o === 1'b1) seen = 1'b1;
      end
      chk("miss_no_ack", {31'b0, seen}, 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;

      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 3;
      @(posedge clk); #1;
      chk("drop_ren", {31'b0, node_ren}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (wbs_ack_o === 1'b1) seen = 1'b1;
      end
      chk("drop_no_ack", {31'b0, seen}, 32'd0);
      do_write(BASE + 4, nd(44), 4'hF, 1'b0, 1'b0, 1, "after_drop");

      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 10; dat_i = nd(99); sel = 4'hF;
      @(posedge clk); #1;
      chk("mid_rst_in_wrack", {31'b0, wbs_ack_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_no_ack", {31'b0, wbs_ack_o}, 32'd0);
      chk("mid_rst_no_wen", {31'b0, node_wen}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      for (int i = 0; i < 64; i++) m_loaded[i] = 1'b0;
      m_cnt = 0; m_err = 1'b0;
      @(posedge clk); #1;
      chk_status("mid_rst");
      do_read(BASE + 10, "rd10_not_committed");

      do_write(BASE + 20, nd(20), 4'hF, 1'b0, 1'b0, 1, "wr20");
      do_write(BASE + 21, nd(21), 4'b0011, 1'b0, 1'b0, 1, "wr21_sel");
      chk_status("pre_clear");
      do_write(BASE + 30, nd(30), 4'hF, 1'b0, 1'b1, 1, "wr30_clear");
      chk_status("clear_write");
      do_write(BASE + 20, nd(120), 4'hF, 1'b0, 1'b0, 1, "wr20_again");
      chk_status("after_clear");
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      for (int i = 0; i < 64; i++) m_loaded[i] = 1'b0;
      m_cnt = 0; m_err = 1'b0;
      chk_status("clear_only");

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
